// File: rtl/la_ram_pkg.sv
// Shared helpers for the lambdalib dual-port RAM family: latency bound, range
// check and the masked-merge primitive used for writes and forwarding.
package la_ram_pkg;

    localparam int unsigned LAT_MAX = 2;

    function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

    // Bitwise masked merge: mask bit 1 takes the new bit, 0 keeps the old bit.
    function automatic logic merge_bit(input logic din, input logic old, input logic mask);
        return mask ? din : old;
    endfunction

endpackage

// File: rtl/la_dpram_fwd_core.sv
// DEPTH x DW storage with per-bit masked write and a one-cycle registered read.
// Callers must only raise we/re for in-range addresses.
module la_dpram_fwd_core
    import la_ram_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 10,
    parameter int unsigned DEPTH = 2 ** AW,
    parameter string       PROP  = "DEFAULT"
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wmask,
    input  logic [DW-1:0] din,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    if (PROP == "DEFAULT") begin : g_default
        logic [DW-1:0] mem [DEPTH];

        // Read-before-write: a same-cycle read of the written word returns the old word.
        always_ff @(posedge clk) begin
            if (we) begin
                for (int i = 0; i < DW; i++) begin
                    if (wmask[i]) mem[waddr][i] <= din[i];
                end
            end
            if (re) rdata <= mem[raddr];
        end
    end else begin : g_macro_fallback
        // No hard macros are bundled here; any other selector uses the same array.
        logic [DW-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we) begin
                for (int i = 0; i < DW; i++) begin
                    if (wmask[i]) mem[waddr][i] <= din[i];
                end
            end
            if (re) rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/la_dpram_fwd.sv
// Single-clock 1W/1R RAM with configurable read latency, read-during-write
// forwarding, non-power-of-two depth with range errors and a read-valid pipeline.
module la_dpram_fwd
    import la_ram_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 10,
    parameter int unsigned DEPTH  = 2 ** AW,
    parameter int unsigned OREG   = 0,
    parameter int unsigned BYPASS = 1,
    parameter string       PROP   = "DEFAULT",
    parameter int unsigned CTRLW  = 128,
    parameter int unsigned TESTW  = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_ce,
    input  logic             wr_we,
    input  logic [DW-1:0]    wr_wmask,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DW-1:0]    wr_din,
    input  logic             rd_ce,
    input  logic [AW-1:0]    rd_addr,
    output logic [DW-1:0]    rd_dout,
    output logic             rd_valid,
    output logic             rd_err,
    input  logic [CTRLW-1:0] ctrl,
    input  logic [TESTW-1:0] test
);

    localparam int unsigned LAT = 1 + OREG;

    logic               wr_ok;
    logic               rd_in;
    logic               rd_ok;
    logic               fwd_hit;
    logic [DW-1:0]      core_rdata;
    logic [DW-1:0]      s1_data;

    logic [LAT_MAX-1:0] vld_q;
    logic [LAT_MAX-1:0] err_q;
    logic               fwd_q;
    logic [DW-1:0]      fwd_din_q;
    logic [DW-1:0]      fwd_mask_q;
    logic [DW-1:0]      dout_q;

    assign wr_ok   = wr_ce & wr_we & in_range(32'(wr_addr), DEPTH);
    assign rd_in   = in_range(32'(rd_addr), DEPTH);
    assign rd_ok   = rd_ce & rd_in;
    assign fwd_hit = (BYPASS != 0) & wr_ok & rd_ok & (wr_addr == rd_addr);

    la_dpram_fwd_core #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH),
        .PROP  (PROP)
    ) u_core (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_addr),
        .wmask (wr_wmask),
        .din   (wr_din),
        .re    (rd_ok),
        .raddr (rd_addr),
        .rdata (core_rdata)
    );

    // Collision state is captured in the accept cycle only, so later writes
    // cannot disturb a read already in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q      <= '0;
            err_q      <= '0;
            fwd_q      <= 1'b0;
            fwd_din_q  <= '0;
            fwd_mask_q <= '0;
        end else begin
            vld_q <= {vld_q[LAT_MAX-2:0], rd_ce};
            err_q <= {err_q[LAT_MAX-2:0], rd_ce & ~rd_in};
            fwd_q <= fwd_hit;
            if (fwd_hit) begin
                fwd_din_q  <= wr_din;
                fwd_mask_q <= wr_wmask;
            end
        end
    end

    always_comb begin
        s1_data = core_rdata;
        if (err_q[0]) begin
            s1_data = '0;
        end else if (fwd_q) begin
            for (int i = 0; i < DW; i++) begin
                s1_data[i] = merge_bit(fwd_din_q[i], core_rdata[i], fwd_mask_q[i]);
            end
        end
    end

    // Doubles as the output register (OREG=1) and the hold register (OREG=0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q <= '0;
        end else if (vld_q[0]) begin
            dout_q <= s1_data;
        end
    end

    assign rd_dout  = ((OREG == 0) && vld_q[0]) ? s1_data : dout_q;
    assign rd_valid = vld_q[LAT-1];
    assign rd_err   = err_q[LAT-1];

    logic unused_bits;
    assign unused_bits = ^{ctrl, test, vld_q, err_q};

endmodule
